// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer
//   Walks data memory from word 0 to DUMP_LEN-1 through a 1-cycle-latency read
//   port and serialises each word MS byte first onto a valid/ready byte stream
//   for the UART transmitter. Used for post-run memory dumps.
// Ports
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   start_i        1-cycle dump request, honoured only when idle
//   abort_i        synchronous cancel of a dump in progress
//   mem_addr_o     word address to memory
//   mem_rd_en_o    read strobe; mem_rdata_i valid the following cycle
//   mem_rdata_i    read data
//   tx_data_o      byte to UART
//   tx_valid_o     tx_data_o valid
//   tx_ready_i     UART accepts byte when tx_valid_o && tx_ready_i
//   busy_o         high whenever a dump is in progress (including DONE)
//   done_o         1-cycle pulse after the final byte is accepted
module mem_dump_streamer #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DUMP_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              rd_en_q, tx_valid_q, busy_q, done_q;

  // Next-state and datapath update; abort outranks start and byte acceptance.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ: begin
        state_d = abort_i ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
          shift_d = mem_rdata_i;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (tx_ready_i) begin
          shift_d = shift_q << 8;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            if (addr_q == LAST_ADDR) begin
              state_d = DONE;
            end else begin
              state_d = READ;
              addr_d  = addr_q + ADDR_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; strobes are decoded from the next state
  // so each output is a flop that tracks the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rd_en_q    <= (state_d == READ);
      tx_valid_q <= (state_d == SEND);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_rd_en_o = rd_en_q;
  assign tx_data_o   = shift_q[DATA_W-1 -: 8];
  assign tx_valid_o  = tx_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: per-cycle vector table for a full
// 4-word dump on a 2-bit address space, plus hand-written stall, start-held,
// abort and asynchronous-reset sequences.
module tb_mem_dump_streamer;

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DUMP_LEN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort, tx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  mem_dump_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMP_LEN(DUMP_LEN)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
    .mem_addr_o(mem_addr), .mem_rd_en_o(mem_rd_en), .mem_rdata_i(mem_rdata),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model: mem[i] = A0B0 + i, junk when not strobed.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 16'hA0B0 + 16'(mem_addr);
    else           mem_rdata <= 16'hDEAD;
  end

  typedef struct packed {
    logic       start, abort, ready;
    logic       busy, valid, rd_en, done;
    logic [7:0] data;
    logic [1:0] addr;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    return (k % 2 == 0) ? 8'hA0 : 8'(8'hB0 + k / 2);
  endfunction

  initial begin
    int got, dones, nbytes;
    logic prev_stall;
    logic [7:0] prev_data;
    logic found;

    // start, abort, ready | busy, valid, rd_en, done, data, addr
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0}; // READ
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0}; // WAIT
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd0}; // first valid
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB0, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB1, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 2'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd3};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 2'd3};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB3, 2'd3};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3}; // DONE, no wrap
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3}; // IDLE, addr held

    // Reset state
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    #3;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_data",  32'(tx_data), 0);
    step();
    reset = 1'b0;
    step();

    // Full dump, tx_ready held high
    foreach (vecs[i]) begin
      start = vecs[i].start; abort = vecs[i].abort; tx_ready = vecs[i].ready;
      step();
      chk($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].busy));
      chk($sformatf("v%0d_valid", i), 32'(tx_valid),  32'(vecs[i].valid));
      chk($sformatf("v%0d_rd_en", i), 32'(mem_rd_en), 32'(vecs[i].rd_en));
      chk($sformatf("v%0d_done", i),  32'(done),      32'(vecs[i].done));
      chk($sformatf("v%0d_addr", i),  32'(mem_addr),  32'(vecs[i].addr));
      if (vecs[i].valid) chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(vecs[i].data));
    end

    // Random tx_ready stalls: order, stability, busy, single done
    tx_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    got = 0; dones = 0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        dones++;
        break;
      end
      chk("t2_busy", 32'(busy), 1);
      if (prev_stall) begin
        chk("t2_stall_valid", 32'(tx_valid), 1);
        chk("t2_stall_data", 32'(tx_data), 32'(prev_data));
      end
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        if (got < 8) chk($sformatf("t2_byte%0d", got), 32'(tx_data), 32'(exp_byte(got)));
        got++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      step();
    end
    chk("t2_byte_count", 32'(got), 8);
    chk("t2_done_seen", 32'(dones), 1);
    step();
    chk("t2_done_single", 32'(done), 0);
    chk("t2_idle_busy", 32'(busy), 0);

    // start held high across a dump
    tx_ready = 1'b1; start = 1'b1;
    nbytes = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done) break;
      if (tx_valid) nbytes++;
    end
    chk("t3_bytes", 32'(nbytes), 8);
    chk("t3_done", 32'(done), 1);
    step();
    chk("t3_idle", 32'(busy), 0);
    step();
    chk("t3_restart_rd", 32'(mem_rd_en), 1);
    chk("t3_restart_addr", 32'(mem_addr), 0);
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_abort_idle", 32'(busy), 0);

    // abort during SEND of word 2 while stalled
    tx_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (tx_valid && mem_addr == 2'd1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("t4_reach_word2", 32'(found), 1);
    tx_ready = 1'b0;
    step();
    chk("t4_stall_valid", 32'(tx_valid), 1);
    chk("t4_stall_data", 32'(tx_data), 32'h A0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_valid", 32'(tx_valid), 0);
    chk("t4_rd_en", 32'(mem_rd_en), 0);
    chk("t4_done", 32'(done), 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_quiet_done", 32'(done), 0);
      chk("t4_quiet_busy", 32'(busy), 0);
    end
    tx_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_restart_rd", 32'(mem_rd_en), 1);
    chk("t4_restart_addr", 32'(mem_addr), 0);

    // Asynchronous reset in the middle of WAIT
    step();
    chk("t5_in_wait_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rd_en", 32'(mem_rd_en), 0);
    chk("t5_valid", 32'(tx_valid), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_addr", 32'(mem_addr), 0);
    chk("t5_data", 32'(tx_data), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_quiet_busy", 32'(busy), 0);
      chk("t5_quiet_rd", 32'(mem_rd_en), 0);
      chk("t5_quiet_valid", 32'(tx_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
